// File: rtl/log_drain_ctrl.sv
// ---------------------------------------------------------------------------
// log_drain_ctrl
//
// Purpose
//   Drains a BRAM-resident event log onto a 32-bit valid/ready stream. The
//   log holds NUM_LOG_ENTRIES entries of 96 bits. Each entry is stored as
//   three consecutive 32-bit words:
//     word 3k   : entry k bits [31:0]  (timestamp)
//     word 3k+1 : entry k bits [63:32] (address)
//     word 3k+2 : entry k bits [95:64] (len/id)
//   Words are read one at a time in address order. A drain starts on an
//   explicit request or automatically when the logger reports nearly-full.
//   The drain ends with a one-cycle clear pulse back to the logger.
//
// Parameters
//   NUM_LOG_ENTRIES : number of 96-bit entries (multiple of 1024, >= 1024)
//   BRAM_ADDR_BITW  : byte-address width of the BRAM port
//
// Ports
//   Clk_CI       in   clock, rising edge
//   Rst_RBI      in   asynchronous active-low reset
//   Start_SI     in   drain request, only looked at while idle
//   AutoEn_SI    in   allow automatic drain on Full_SI
//   Full_SI      in   logger nearly-full level
//   Abort_SI     in   terminate an ongoing drain
//   BramEn_SO    out  BRAM enable, one cycle per word read
//   BramAddr_DO  out  BRAM byte address (word aligned, 0 when not enabled)
//   BramWrEn_SO  out  BRAM byte write enables, tied to 0 (read-only port)
//   BramRd_DI    in   BRAM read data, valid one cycle after the address
//   OutValid_SO  out  stream valid
//   OutReady_SI  in   stream ready
//   OutData_DO   out  stream data
//   OutLast_SO   out  marks the final word of a drain
//   Clear_SO     out  one-cycle clear pulse to the logger
//   Busy_SO      out  high whenever a drain is in progress
//   Done_SO      out  one-cycle pulse when a drain completes or is aborted
// ---------------------------------------------------------------------------
module log_drain_ctrl #(
  parameter int NUM_LOG_ENTRIES = 16384,
  parameter int BRAM_ADDR_BITW  = 32
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RBI,
  input  logic                      Start_SI,
  input  logic                      AutoEn_SI,
  input  logic                      Full_SI,
  input  logic                      Abort_SI,
  output logic                      BramEn_SO,
  output logic [BRAM_ADDR_BITW-1:0] BramAddr_DO,
  output logic [3:0]                BramWrEn_SO,
  input  logic [31:0]               BramRd_DI,
  output logic                      OutValid_SO,
  input  logic                      OutReady_SI,
  output logic [31:0]               OutData_DO,
  output logic                      OutLast_SO,
  output logic                      Clear_SO,
  output logic                      Busy_SO,
  output logic                      Done_SO
);

  localparam int NUM_WORDS = 3 * NUM_LOG_ENTRIES;
  localparam int CNT_W     = $clog2(NUM_WORDS);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_SEND     = 3'd3,
    S_CLEAR    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_data;
  logic             w_capture;
  logic             r_armed;
  logic             w_armed_nxt;
  logic             w_start_req;
  logic             w_is_last;
  logic [BRAM_ADDR_BITW-1:0] w_byte_addr;

  // Automatic start needs the re-arm flag so a Full level that is still high
  // after a drain does not immediately launch another one.
  assign w_start_req = Start_SI | (AutoEn_SI & Full_SI & r_armed);
  assign w_is_last   = (r_cnt == LAST_CNT);
  // Word index to byte address; the cast zero-extends or truncates to the
  // port width.
  assign w_byte_addr = BRAM_ADDR_BITW'({r_cnt, 2'b00});

  // ---- state, counter and re-arm registers ----
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  // ---- output data register: loaded once per word, held through stalls ----
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_data <= '0;
    end else if (w_capture) begin
      r_data <= BramRd_DI;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_armed_nxt = r_armed;
    w_capture   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Full seen low while idle re-arms the automatic trigger. Abort is
        // meaningless here and is not looked at.
        if (!Full_SI) begin
          w_armed_nxt = 1'b1;
        end
        if (w_start_req) begin
          w_state_nxt = S_RD_ISSUE;
          w_cnt_nxt   = '0;
        end
      end

      S_RD_ISSUE: begin
        w_state_nxt = Abort_SI ? S_CLEAR : S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (Abort_SI) begin
          w_state_nxt = S_CLEAR;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = S_SEND;
        end
      end

      S_SEND: begin
        // Abort has priority over the handshake: the pending word is dropped.
        if (Abort_SI) begin
          w_state_nxt = S_CLEAR;
        end else if (OutReady_SI) begin
          if (w_is_last) begin
            w_state_nxt = S_CLEAR;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_ONE;
            w_state_nxt = S_RD_ISSUE;
          end
        end
      end

      S_CLEAR: begin
        // Every drain, completed or aborted, disarms the automatic trigger
        // until Full has been seen low again.
        w_armed_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- outputs, decoded from state ----
  always_comb begin
    BramEn_SO   = 1'b0;
    BramAddr_DO = '0;
    OutValid_SO = 1'b0;
    OutLast_SO  = 1'b0;
    Clear_SO    = 1'b0;
    Done_SO     = 1'b0;
    Busy_SO     = (r_state != S_IDLE);

    case (r_state)
      S_RD_ISSUE: begin
        BramEn_SO   = 1'b1;
        BramAddr_DO = w_byte_addr;
      end
      S_SEND: begin
        OutValid_SO = 1'b1;
        OutLast_SO  = w_is_last;
      end
      S_CLEAR: begin
        Clear_SO = 1'b1;
        Done_SO  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign BramWrEn_SO = 4'b0000;
  assign OutData_DO  = r_data;

endmodule

// File: tb/tb_log_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_log_drain_ctrl
//
// Directed bench for log_drain_ctrl with NUM_LOG_ENTRIES=1024 (3072 words).
// A behavioural BRAM with one-cycle read latency holds a known log pattern;
// expected stream words are computed from the entry fields directly.
// ---------------------------------------------------------------------------
module tb_log_drain_ctrl;

  localparam int NLE = 1024;
  localparam int NW  = 3 * NLE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, auto_en, full, abort_i, ready;
  logic        bram_en;
  logic [31:0] bram_addr;
  logic [3:0]  bram_wren;
  logic [31:0] bram_rd;
  logic        out_valid, out_last, clear_o, busy, done;
  logic [31:0] out_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  log_drain_ctrl #(
    .NUM_LOG_ENTRIES(NLE),
    .BRAM_ADDR_BITW (32)
  ) dut (
    .Clk_CI     (clk),
    .Rst_RBI    (rst_n),
    .Start_SI   (start),
    .AutoEn_SI  (auto_en),
    .Full_SI    (full),
    .Abort_SI   (abort_i),
    .BramEn_SO  (bram_en),
    .BramAddr_DO(bram_addr),
    .BramWrEn_SO(bram_wren),
    .BramRd_DI  (bram_rd),
    .OutValid_SO(out_valid),
    .OutReady_SI(ready),
    .OutData_DO (out_data),
    .OutLast_SO (out_last),
    .Clear_SO   (clear_o),
    .Busy_SO    (busy),
    .Done_SO    (done)
  );

  // Log entry k: {len/id, address, timestamp}
  function automatic logic [95:0] entry96(input int k);
    logic [31:0] ts, ad, li;
    ts = 32'h5000_0000 + 32'(k * 7);
    ad = 32'hA000_0000 + 32'(k * 16);
    li = 32'hC000_0000 | 32'(k);
    return {li, ad, ts};
  endfunction

  function automatic logic [31:0] bram_word(input logic [31:0] byte_addr);
    int w;
    logic [95:0] e;
    w = int'(byte_addr >> 2);
    e = entry96(w / 3);
    return e[(w % 3) * 32 +: 32];
  endfunction

  function automatic logic [31:0] exp_word(input int i);
    int k;
    k = i / 3;
    case (i % 3)
      0:       return 32'h5000_0000 + 32'(k * 7);
      1:       return 32'hA000_0000 + 32'(k * 16);
      default: return 32'hC000_0000 | 32'(k);
    endcase
  endfunction

  // BRAM: one-cycle latency; garbage when not enabled.
  always @(posedge clk) begin
    bram_rd <= bram_en ? bram_word(bram_addr) : $urandom();
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({bram_en, out_valid, out_last, clear_o, busy, done, bram_wren}), 64'(0));
    chk({tag, "_addr"}, 64'(bram_addr), 64'(0));
    chk({tag, "_data"}, 64'(out_data), 64'(0));
  endtask

  // Launch a drain and check the first two cycles (RD_ISSUE, RD_WAIT).
  task automatic kick(input string tag, input bit use_auto);
    @(negedge clk);
    if (use_auto) begin
      auto_en = 1'b1;
      full    = 1'b1;
    end else begin
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_iss_busy"}, 64'(busy), 64'(1));
    chk({tag, "_iss_en"}, 64'(bram_en), 64'(1));
    chk({tag, "_iss_addr"}, 64'(bram_addr), 64'(0));
    chk({tag, "_iss_valid"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    chk({tag, "_wait_en"}, 64'(bram_en), 64'(0));
    chk({tag, "_wait_valid"}, 64'(out_valid), 64'(0));
  endtask

  // Receive n_words words starting at word 0. rnd selects random ready;
  // pulse_at >= 0 fires Start/AutoEn/Full for one cycle mid-drain.
  task automatic run_drain(input string tag, input int n_words, input bit rnd,
                           input int pulse_at, output int got);
    int idx = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] held = '0;
    while (idx < n_words && cyc < 20 * n_words + 50) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk({tag, "_stall_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_stall_data"}, 64'(out_data), 64'(held));
        chk({tag, "_stall_bram"}, 64'(bram_en), 64'(0));
      end
      if (bram_en) begin
        chk({tag, "_rd_addr"}, 64'(bram_addr), 64'(32'(idx * 4)));
      end
      start = (cyc == pulse_at);
      if (pulse_at >= 0) begin
        auto_en = (cyc == pulse_at);
        full    = (cyc == pulse_at);
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (ready) begin
          chk({tag, "_data"}, 64'(out_data), 64'(exp_word(idx)));
          chk({tag, "_last"}, 64'(out_last), 64'(idx == NW - 1));
          if (!rnd) begin
            chk({tag, "_gap"}, 64'(cyc - last_cyc), 64'((idx == 0) ? 1 : 3));
          end
          last_cyc = cyc;
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = out_data;
        end
      end
    end
    start = 1'b0;
    got = idx;
  endtask

  task automatic check_clear(input string tag);
    @(negedge clk);
    ready = 1'b0;
    chk({tag, "_clr_pulse"}, 64'({clear_o, done, busy, out_valid, bram_en}), 64'(5'b11100));
    @(negedge clk);
    chk({tag, "_clr_end"}, 64'({clear_o, done, busy}), 64'(3'b000));
  endtask

  initial begin
    int got;
    bit seen;
    rst_n   = 1'b0;
    start   = 1'b0;
    auto_en = 1'b0;
    full    = 1'b0;
    abort_i = 1'b0;
    ready   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));

    // Full drain, ready always high: latency, order, last, clear
    kick("t1", 1'b0);
    run_drain("t1", NW, 1'b0, -1, got);
    chk("t1_count", 64'(got), 64'(NW));
    check_clear("t1");

    // Random backpressure with a Start/Auto/Full pulse while busy
    kick("t2", 1'b0);
    run_drain("t2", NW, 1'b1, 50, got);
    chk("t2_count", 64'(got), 64'(NW));
    check_clear("t2");

    // Abort during SEND of word 100
    kick("t3", 1'b0);
    run_drain("t3", 100, 1'b0, -1, got);
    chk("t3_count", 64'(got), 64'(100));
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      ready = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    chk("t3_send100", 64'(seen), 64'(1));
    chk("t3_word100", 64'(out_data), 64'(exp_word(100)));
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("t3_abort_valid", 64'(out_valid), 64'(0));
    chk("t3_abort_clr", 64'({clear_o, done}), 64'(2'b11));
    @(negedge clk);
    chk("t3_abort_end", 64'({clear_o, done, busy}), 64'(3'b000));

    // Auto drain with Full held high: exactly one drain
    kick("t4", 1'b1);
    run_drain("t4", NW, 1'b0, -1, got);
    chk("t4_count", 64'(got), 64'(NW));
    check_clear("t4");
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("t4_no_retrig", 64'(seen), 64'(0));
    full = 1'b0;
    @(negedge clk);
    full = 1'b1;
    @(negedge clk);
    chk("t4_rearm_busy", 64'(busy), 64'(1));
    chk("t4_rearm_addr", 64'({bram_en, bram_addr}), 64'({1'b1, 32'h0}));
    abort_i = 1'b1;
    auto_en = 1'b0;
    full    = 1'b0;
    @(negedge clk);
    abort_i = 1'b0;
    chk("t4_abort_clr", 64'({clear_o, done}), 64'(2'b11));
    @(negedge clk);
    chk("t4_abort_end", 64'(busy), 64'(0));

    // Reset at word 500
    kick("t5", 1'b0);
    run_drain("t5", 500, 1'b0, -1, got);
    chk("t5_count", 64'(got), 64'(500));
    @(negedge clk);
    chk("t5_rd500", 64'({bram_en, bram_addr}), 64'({1'b1, 32'd2000}));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async_rst");
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (clear_o || done) seen = 1'b1;
    end
    chk("t5_no_clear", 64'(seen), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle", 64'(busy), 64'(0));
    kick("t5b", 1'b0);
    run_drain("t5b", 3, 1'b0, -1, got);
    chk("t5b_count", 64'(got), 64'(3));
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("t5b_abort_clr", 64'({clear_o, done}), 64'(2'b11));
    @(negedge clk);
    chk("t5b_abort_end", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
